// File: rtl/stream_frame_buffer_pkg.sv
// ============================================================================
// Module : stream_frame_buffer_pkg
// Brief  : Shared byte-stream definitions used by every stage of the stream path.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package stream_frame_buffer_pkg;

    localparam int STREAM_DATA_WIDTH = 8;
    localparam int STREAM_FIFO_DEPTH = 16;
    localparam int STREAM_ADDR_WIDTH = $clog2(STREAM_FIFO_DEPTH);

endpackage

`default_nettype wire

// File: rtl/stream_fifo_mem.sv
// ============================================================================
// Module : stream_fifo_mem
// Brief  : DEPTH x WIDTH storage, synchronous write, asynchronous (FWFT) read.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module stream_fifo_mem
    import stream_frame_buffer_pkg::*;
#(
    parameter int WIDTH      = STREAM_DATA_WIDTH + 1,
    parameter int DEPTH      = STREAM_FIFO_DEPTH,
    parameter int ADDR_WIDTH = STREAM_ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    // No reset: contents are only meaningful between the FIFO pointers.
    logic [WIDTH-1:0] mem_q [0:DEPTH-1];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

`default_nettype wire

// File: rtl/stream_frame_buffer.sv
// ============================================================================
// Module : stream_frame_buffer
// Brief  : Frame-aware FIFO between the byte processor and its sink, with
//          upstream throttling and optional store-and-forward release.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module stream_frame_buffer
    import stream_frame_buffer_pkg::*;
#(
    parameter int DATA_WIDTH        = STREAM_DATA_WIDTH,
    parameter int DEPTH             = STREAM_FIFO_DEPTH,
    parameter int ADDR_WIDTH        = STREAM_ADDR_WIDTH,
    parameter bit STORE_AND_FORWARD = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  upstream_enable,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH:0]   level,
    output logic [ADDR_WIDTH:0]   frames,
    output logic                  oversize
);

    localparam logic [ADDR_WIDTH:0] LEVEL_FULL = (ADDR_WIDTH + 1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   level_q, level_d;
    logic [ADDR_WIDTH:0]   frames_q, frames_d;
    logic                  release_q, release_d;
    logic                  oversize_q, oversize_d;
    logic                  wr_en, rd_en;
    logic [DATA_WIDTH:0]   rd_entry;

    // Enable comes from registered level only, so a same-cycle pop never reopens a full buffer.
    assign upstream_enable = (level_q != LEVEL_FULL);
    assign wr_en           = in_valid && upstream_enable;
    assign out_valid       = (level_q != '0) &&
                             (!STORE_AND_FORWARD || (frames_q != '0) || release_q);
    assign rd_en           = out_valid && out_ready;

    assign out_data = rd_entry[DATA_WIDTH-1:0];
    assign out_last = rd_entry[DATA_WIDTH];
    assign level    = level_q;
    assign frames   = frames_q;
    assign oversize = oversize_q;

    stream_fifo_mem #(
        .WIDTH      (DATA_WIDTH + 1),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clock   (clock),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q),
        .wr_data ({in_last, in_data}),
        .rd_addr (rd_ptr_q),
        .rd_data (rd_entry)
    );

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        frames_d   = frames_q;
        release_d  = release_q;
        oversize_d = oversize_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({wr_en, rd_en})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        case ({wr_en && in_last, rd_en && out_last})
            2'b10:   frames_d = frames_q + 1'b1;
            2'b01:   frames_d = frames_q - 1'b1;
            default: frames_d = frames_q;
        endcase

        // A full buffer holding no frame end can never complete a frame: fall back to cut-through.
        if (STORE_AND_FORWARD) begin
            if ((level_q == LEVEL_FULL) && (frames_q == '0)) begin
                release_d  = 1'b1;
                oversize_d = 1'b1;
            end else if (rd_en && out_last) begin
                release_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            frames_q   <= '0;
            release_q  <= 1'b0;
            oversize_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            frames_q   <= frames_d;
            release_q  <= release_d;
            oversize_q <= oversize_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_stream_frame_buffer.sv
// ============================================================================
// Module : tb_stream_frame_buffer
// Brief  : Self-checking bench: cut-through and store-and-forward instances.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_stream_frame_buffer;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          reset_s         [2];
    logic [DW-1:0] in_data         [2];
    logic          in_valid        [2];
    logic          in_last         [2];
    logic          out_ready       [2];
    logic          upstream_enable [2];
    logic [DW-1:0] out_data        [2];
    logic          out_valid       [2];
    logic          out_last        [2];
    logic [AW:0]   level           [2];
    logic [AW:0]   frames          [2];
    logic          oversize        [2];

    int errors = 0;
    int checks = 0;
    logic [DW:0] sb0[$];
    logic [DW:0] sb1[$];

    // Instance 0 is cut-through, instance 1 is store-and-forward.
    stream_frame_buffer #(
        .DATA_WIDTH (DW), .DEPTH (DEPTH), .ADDR_WIDTH (AW), .STORE_AND_FORWARD (1'b0)
    ) u_ct (
        .clock (clock), .reset (reset_s[0]),
        .in_data (in_data[0]), .in_valid (in_valid[0]), .in_last (in_last[0]),
        .upstream_enable (upstream_enable[0]),
        .out_data (out_data[0]), .out_valid (out_valid[0]), .out_last (out_last[0]),
        .out_ready (out_ready[0]),
        .level (level[0]), .frames (frames[0]), .oversize (oversize[0])
    );

    stream_frame_buffer #(
        .DATA_WIDTH (DW), .DEPTH (DEPTH), .ADDR_WIDTH (AW), .STORE_AND_FORWARD (1'b1)
    ) u_sf (
        .clock (clock), .reset (reset_s[1]),
        .in_data (in_data[1]), .in_valid (in_valid[1]), .in_last (in_last[1]),
        .upstream_enable (upstream_enable[1]),
        .out_data (out_data[1]), .out_valid (out_valid[1]), .out_last (out_last[1]),
        .out_ready (out_ready[1]),
        .level (level[1]), .frames (frames[1]), .oversize (oversize[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input int s, input logic [DW:0] v);
        if (s == 0) sb0.push_back(v);
        else        sb1.push_back(v);
    endtask

    // Acts like the processor: holds the byte until the buffer's enable is high.
    task automatic send(input int s, input logic [DW-1:0] d, input logic l);
        int budget = 100;
        in_data[s]  = d;
        in_last[s]  = l;
        in_valid[s] = 1'b1;
        while (upstream_enable[s] !== 1'b1 && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) begin
            in_valid[s] = 1'b0;
            chk("send_timeout", 32'(upstream_enable[s]), 32'd1);
        end else begin
            push(s, {l, d});
            tick();
            in_valid[s] = 1'b0;
        end
    endtask

    task automatic wait_level(input int s, input logic [AW:0] target, input string tag);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (level[s] !== target && n < 200);
        chk(tag, 32'(level[s]), 32'(target));
    endtask

    task automatic mon(input int s);
        logic [DW:0] e;
        int sz;
        sz = (s == 0) ? sb0.size() : sb1.size();
        chk("sb_has_entry", 32'(sz != 0), 32'd1);
        if (sz != 0) begin
            e = (s == 0) ? sb0.pop_front() : sb1.pop_front();
            chk("sb_beat", 32'({out_last[s], out_data[s]}), 32'(e));
        end
    endtask

    always @(negedge clock) begin
        for (int s = 0; s < 2; s++) begin
            if (out_valid[s] === 1'b1 && out_ready[s] === 1'b1) mon(s);
        end
    end

    task automatic chk_reset(input int s, input string tag);
        chk({tag, "_level"},  32'(level[s]),           32'd0);
        chk({tag, "_frames"}, 32'(frames[s]),          32'd0);
        chk({tag, "_valid"},  32'(out_valid[s]),       32'd0);
        chk({tag, "_enable"}, 32'(upstream_enable[s]), 32'd1);
        chk({tag, "_over"},   32'(oversize[s]),        32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int s = 0; s < 2; s++) begin
            reset_s[s] = 1'b1; in_valid[s] = 1'b0; in_last[s] = 1'b0;
            in_data[s] = '0;   out_ready[s] = 1'b0;
        end
        tick(); tick();
        reset_s[0] = 1'b0;
        reset_s[1] = 1'b0;
        @(negedge clock);
        chk_reset(0, "rst_ct");
        chk_reset(1, "rst_sf");
        tick();

        // 1: cut-through, one cycle from write to presentation
        out_ready[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(0, 8'(8'h10 + i), i == 2);
            @(negedge clock);
            chk("t1_latency", 32'(out_valid[0]), 32'd1);
            chk("t1_level",   32'(level[0]),     32'd1);
            chk("t1_last",    32'(out_last[0]),  32'(i == 2));
            tick();
        end
        @(negedge clock);
        chk("t1_level_end", 32'(level[0]), 32'd0);
        tick();
        chk("t1_sb_empty", 32'(sb0.size()), 32'd0);

        // 2: store-and-forward holds until the frame end is buffered
        out_ready[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(1, 8'(8'hA0 + i), i == 3);
            @(negedge clock);
            chk("t2_valid", 32'(out_valid[1]), 32'(i == 3));
            if (i != 3) tick();
        end
        chk("t2_frames", 32'(frames[1]), 32'd1);
        chk("t2_level",  32'(level[1]),  32'd4);
        for (int j = 1; j < 4; j++) begin
            @(negedge clock);
            chk("t2_pop_valid", 32'(out_valid[1]), 32'd1);
            chk("t2_pop_level", 32'(level[1]),     32'(4 - j));
        end
        @(negedge clock);
        chk("t2_end_level",  32'(level[1]),     32'd0);
        chk("t2_end_frames", 32'(frames[1]),    32'd0);
        chk("t2_end_valid",  32'(out_valid[1]), 32'd0);
        tick();
        chk("t2_sb_empty", 32'(sb1.size()), 32'd0);

        // 3: stalled sink fills the buffer, then drains with no repeats
        out_ready[0] = 1'b0;
        fork
            begin
                for (int i = 0; i < 20; i++) send(0, 8'(8'h30 + i), i == 19);
            end
            begin
                wait_level(0, 5'd16, "t3_full");
                chk("t3_enable_low", 32'(upstream_enable[0]), 32'd0);
                repeat (3) @(negedge clock);
                chk("t3_level_hold",  32'(level[0]),           32'd16);
                chk("t3_enable_hold", 32'(upstream_enable[0]), 32'd0);
                tick();
                out_ready[0] = 1'b1;
            end
        join
        wait_level(0, 5'd0, "t3_drain");
        tick();
        chk("t3_sb_empty", 32'(sb0.size()), 32'd0);

        // 4: oversize frame in store-and-forward falls back to cut-through
        fork
            begin
                for (int i = 0; i < 20; i++) send(1, 8'(8'h60 + i), i == 19);
            end
            begin
                wait_level(1, 5'd16, "t4_full");
                chk("t4_frames0", 32'(frames[1]), 32'd0);
                @(negedge clock);
                chk("t4_oversize", 32'(oversize[1]),  32'd1);
                chk("t4_release",  32'(out_valid[1]), 32'd1);
                tick();
            end
        join
        wait_level(1, 5'd0, "t4_drain");
        tick();
        chk("t4_sb_empty", 32'(sb1.size()), 32'd0);
        send(1, 8'h80, 1'b0);
        @(negedge clock);
        chk("t4_release_cleared", 32'(out_valid[1]), 32'd0);
        chk("t4_oversize_sticky", 32'(oversize[1]),  32'd1);
        tick();
        send(1, 8'h81, 1'b1);
        @(negedge clock);
        chk("t4_frame_valid", 32'(out_valid[1]), 32'd1);
        wait_level(1, 5'd0, "t4_drain2");
        tick();

        // 5: simultaneous write-with-last and pop-with-last
        out_ready[1] = 1'b0;
        send(1, 8'hB0, 1'b1);
        @(negedge clock);
        chk("t5_pre_frames", 32'(frames[1]), 32'd1);
        tick();
        out_ready[1] = 1'b1;
        send(1, 8'hC0, 1'b1);
        @(negedge clock);
        chk("t5_frames", 32'(frames[1]), 32'd1);
        chk("t5_level",  32'(level[1]),  32'd1);
        tick();
        @(negedge clock);
        chk("t5_end_level",  32'(level[1]),  32'd0);
        chk("t5_end_frames", 32'(frames[1]), 32'd0);
        tick();
        chk("t5_sb_empty", 32'(sb1.size()), 32'd0);

        // 6: reset with bytes buffered discards them
        out_ready[0] = 1'b0;
        for (int i = 0; i < 5; i++) send(0, 8'(8'h50 + i), 1'b0);
        @(negedge clock);
        chk("t6_level5", 32'(level[0]), 32'd5);
        tick();
        reset_s[0] = 1'b1;
        tick();
        reset_s[0] = 1'b0;
        @(negedge clock);
        chk_reset(0, "t6_rst");
        sb0.delete();
        tick();
        out_ready[0] = 1'b1;
        send(0, 8'h5A, 1'b1);
        @(negedge clock);
        chk("t6_new_frames", 32'(frames[0]),    32'd1);
        chk("t6_new_valid",  32'(out_valid[0]), 32'd1);
        wait_level(0, 5'd0, "t6_drain");
        tick();
        chk("t6_sb_empty", 32'(sb0.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
